// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Sequencing controller for a 5-stage MIPS pipeline. Chooses
//               per cycle whether each pipeline register advances, holds or
//               loads a bubble (load-use stall, taken-branch flush, halt
//               drain), gates execution with debug run / single-step
//               requests, and keeps advance and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int CNT_SZ = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_id_ex_mem_read,
  input  logic [4:0]        i_id_ex_rt,
  input  logic [4:0]        i_if_id_rs,
  input  logic [4:0]        i_if_id_rt,
  input  logic              i_branch_taken,
  input  logic              i_id_halt,
  input  logic              i_wb_halt,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_en,
  output logic              o_id_ex_flush,
  output logic              o_ex_mem_en,
  output logic              o_mem_wb_en,
  output logic              o_halted,
  output logic [1:0]        o_state,
  output logic [CNT_SZ-1:0] o_cycle_cnt,
  output logic [CNT_SZ-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [4:0] c_REG_ZERO = 5'd0;

  state_t              r_state;
  logic                r_halt_pending;
  logic [CNT_SZ-1:0]   r_cycle_cnt;
  logic [CNT_SZ-1:0]   r_stall_cnt;

  logic                w_adv;
  logic                w_hazard;

  // A cycle advances the pipeline only while running or on the single step
  assign w_adv = (r_state == ST_RUN) || (r_state == ST_STEP);

  // Load-use hazard: the load in ID/EX writes a register the IF/ID
  // instruction reads; $zero never creates a dependency
  assign w_hazard = i_id_ex_mem_read && (i_id_ex_rt != c_REG_ZERO) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

  // Run / step / halt sequencing; HALTED is left only through reset
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_run)       r_state <= ST_RUN;
          else if (i_step) r_state <= ST_STEP;
        end
        ST_RUN: begin
          if (i_wb_halt)   r_state <= ST_HALTED;
          else if (!i_run) r_state <= ST_IDLE;
        end
        ST_STEP: begin
          if (i_wb_halt)   r_state <= ST_HALTED;
          else             r_state <= ST_IDLE;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Remember that the halt instruction has entered ID/EX so fetch stays frozen
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_halt_pending <= 1'b0;
    end else if (w_adv && !w_hazard && i_id_halt) begin
      r_halt_pending <= 1'b1;
    end
  end

  // Debug counters: advance cycles and load-use bubbles, wrapping naturally
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_adv) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_SZ'(1);
      if (w_hazard && !r_halt_pending) begin
        r_stall_cnt <= r_stall_cnt + CNT_SZ'(1);
      end
    end
  end

  // Per-cycle register enables and flushes; drain, then stall, then halt
  // entry, then normal fetch with optional branch flush
  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    if (w_adv) begin
      o_id_ex_en  = 1'b1;
      o_ex_mem_en = 1'b1;
      o_mem_wb_en = 1'b1;
      if (r_halt_pending || w_hazard) begin
        // Hold fetch/decode and push a bubble; a taken branch in ID
        // resolves again next cycle once its operand is ready
        o_id_ex_flush = 1'b1;
      end else if (i_id_halt) begin
        // Let the halt move into ID/EX while fetch stops
        o_id_ex_flush = 1'b0;
      end else begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = i_branch_taken;
      end
    end
  end

  assign o_halted    = (r_state == ST_HALTED);
  assign o_state     = r_state;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed table-driven bench for pipeline_ctrl, plus a
//               hand-written asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int CNT_SZ = 32;
  localparam int NVEC   = 38;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_run = 1'b0;
  logic              i_step = 1'b0;
  logic              i_id_ex_mem_read = 1'b0;
  logic [4:0]        i_id_ex_rt = '0;
  logic [4:0]        i_if_id_rs = '0;
  logic [4:0]        i_if_id_rt = '0;
  logic              i_branch_taken = 1'b0;
  logic              i_id_halt = 1'b0;
  logic              i_wb_halt = 1'b0;
  logic              o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en;
  logic              o_id_ex_flush, o_ex_mem_en, o_mem_wb_en, o_halted;
  logic [1:0]        o_state;
  logic [CNT_SZ-1:0] o_cycle_cnt, o_stall_cnt;

  pipeline_ctrl #(.CNT_SZ(CNT_SZ)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_run            (i_run),
    .i_step           (i_step),
    .i_id_ex_mem_read (i_id_ex_mem_read),
    .i_id_ex_rt       (i_id_ex_rt),
    .i_if_id_rs       (i_if_id_rs),
    .i_if_id_rt       (i_if_id_rt),
    .i_branch_taken   (i_branch_taken),
    .i_id_halt        (i_id_halt),
    .i_wb_halt        (i_wb_halt),
    .o_pc_en          (o_pc_en),
    .o_if_id_en       (o_if_id_en),
    .o_if_id_flush    (o_if_id_flush),
    .o_id_ex_en       (o_id_ex_en),
    .o_id_ex_flush    (o_id_ex_flush),
    .o_ex_mem_en      (o_ex_mem_en),
    .o_mem_wb_en      (o_mem_wb_en),
    .o_halted         (o_halted),
    .o_state          (o_state),
    .o_cycle_cnt      (o_cycle_cnt),
    .o_stall_cnt      (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  // en order: {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb}
  localparam logic [6:0] EN_OFF   = 7'b0000000;
  localparam logic [6:0] EN_FULL  = 7'b1101011;
  localparam logic [6:0] EN_BUB   = 7'b0001111;
  localparam logic [6:0] EN_HALTI = 7'b0001011;
  localparam logic [6:0] EN_BR    = 7'b1111011;

  typedef struct {
    logic        run, step, mr;
    logic [4:0]  exrt, rs, rt;
    logic        br, idh, wbh;
    logic [6:0]  en;
    logic        halted;
    logic [1:0]  st;
    logic [31:0] cyc, stall;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic setv(input int idx, input logic run, input logic step,
                      input logic mr, input logic [4:0] exrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br, input logic idh,
                      input logic wbh, input logic [6:0] en, input logic halted,
                      input logic [1:0] st, input logic [31:0] cyc,
                      input logic [31:0] stall);
    vecs[idx].run = run;   vecs[idx].step = step; vecs[idx].mr = mr;
    vecs[idx].exrt = exrt; vecs[idx].rs = rs;     vecs[idx].rt = rt;
    vecs[idx].br = br;     vecs[idx].idh = idh;   vecs[idx].wbh = wbh;
    vecs[idx].en = en;     vecs[idx].halted = halted;
    vecs[idx].st = st;     vecs[idx].cyc = cyc;   vecs[idx].stall = stall;
  endtask

  function automatic logic [73:0] snap();
    return {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
            o_ex_mem_en, o_mem_wb_en, o_halted, o_state, o_cycle_cnt, o_stall_cnt};
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got en/halt/st/cyc/stall=%h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Reset state, then 10 clean RUN cycles
    setv(0,  0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 0, 0);
    setv(1,  1,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 0, 0);
    for (int k = 0; k < 10; k++)
      setv(2+k, 1,0,0,0,0,0,0,0,0, EN_FULL, 0,2'b01, k, 0);
    setv(12, 1,0,0,0,0,0,0,0,0, EN_FULL, 0,2'b01, 10, 0);
    // Load-use on rs, then rt=0 (no stall), then hazard on rt with branch
    setv(13, 1,0,1,5,5,0,0,0,0, EN_BUB,  0,2'b01, 11, 0);
    setv(14, 1,0,1,0,0,0,0,0,0, EN_FULL, 0,2'b01, 12, 1);
    setv(15, 1,0,1,7,0,7,1,0,0, EN_BUB,  0,2'b01, 13, 1);
    setv(16, 1,0,0,0,0,0,1,0,0, EN_BR,   0,2'b01, 14, 2);
    // Drop run: this cycle still advances, then IDLE
    setv(17, 0,0,0,0,0,0,0,0,0, EN_FULL, 0,2'b01, 15, 2);
    setv(18, 0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 16, 2);
    // Three single steps at 4-cycle spacing; a pulse during STEP is ignored
    setv(19, 0,1,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 16, 2);
    setv(20, 0,0,0,0,0,0,0,0,0, EN_FULL, 0,2'b10, 16, 2);
    setv(21, 0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 17, 2);
    setv(22, 0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 17, 2);
    setv(23, 0,1,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 17, 2);
    setv(24, 0,0,0,0,0,0,0,0,0, EN_FULL, 0,2'b10, 17, 2);
    setv(25, 0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 18, 2);
    setv(26, 0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 18, 2);
    setv(27, 0,1,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 18, 2);
    setv(28, 0,1,0,0,0,0,0,0,0, EN_FULL, 0,2'b10, 18, 2);
    setv(29, 0,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 19, 2);
    // Halt: enters ID/EX, back end drains (hazard ignored, not counted)
    setv(30, 1,0,0,0,0,0,0,0,0, EN_OFF,  0,2'b00, 19, 2);
    setv(31, 1,0,0,0,0,0,0,0,0, EN_FULL, 0,2'b01, 19, 2);
    setv(32, 1,0,0,0,0,0,0,1,0, EN_HALTI,0,2'b01, 20, 2);
    setv(33, 1,0,1,3,3,0,0,0,0, EN_BUB,  0,2'b01, 21, 2);
    setv(34, 1,0,0,0,0,0,1,0,0, EN_BUB,  0,2'b01, 22, 2);
    setv(35, 1,0,0,0,0,0,0,0,1, EN_BUB,  0,2'b01, 23, 2);
    setv(36, 1,0,0,0,0,0,0,0,0, EN_OFF,  1,2'b11, 24, 2);
    setv(37, 0,1,0,0,0,0,0,0,0, EN_OFF,  1,2'b11, 24, 2);

    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      @(negedge i_clk);
      i_run = vecs[v].run;   i_step = vecs[v].step; i_id_ex_mem_read = vecs[v].mr;
      i_id_ex_rt = vecs[v].exrt; i_if_id_rs = vecs[v].rs; i_if_id_rt = vecs[v].rt;
      i_branch_taken = vecs[v].br; i_id_halt = vecs[v].idh; i_wb_halt = vecs[v].wbh;
      #2;
      chk($sformatf("vec%0d", v), snap(),
          {vecs[v].en, vecs[v].halted, vecs[v].st, vecs[v].cyc, vecs[v].stall});
    end

    // Reset clears HALTED; then asynchronous reset in the middle of RUN
    @(negedge i_clk);
    i_reset = 1'b0;
    i_run = 1'b0; i_step = 1'b0; i_id_ex_mem_read = 1'b0; i_id_ex_rt = '0;
    i_if_id_rs = '0; i_if_id_rt = '0; i_branch_taken = 1'b0;
    i_id_halt = 1'b0; i_wb_halt = 1'b0;
    #1;
    chk("reset_from_halted", snap(), {EN_OFF, 1'b0, 2'b00, 32'd0, 32'd0});
    @(negedge i_clk);
    i_reset = 1'b1;
    i_run   = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk);
    #2;
    chk("run_before_reset", snap(), {EN_FULL, 1'b0, 2'b01, 32'd2, 32'd0});
    #1;
    i_reset = 1'b0;
    #1;
    chk("async_reset_midrun", snap(), {EN_OFF, 1'b0, 2'b00, 32'd0, 32'd0});
    @(posedge i_clk);
    #1;
    chk("reset_held_over_edge", snap(), {EN_OFF, 1'b0, 2'b00, 32'd0, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage MIPS pipeline. Decides per cycle which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or load a bubble. It covers load-use hazard stalls, taken-branch flushes, halt draining, and debug-unit run/single-step control. It also keeps advance and stall counters for the debug unit.

## Interface
Parameters:
- CNT_SZ, 32, width of o_cycle_cnt and o_stall_cnt

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_run  in  1  debug unit continuous-run request (level)
- i_step  in  1  debug unit single-step request (1-cycle pulse)
- i_id_ex_mem_read  in  1  MemRead currently held in ID/EX
- i_id_ex_rt  in  5  rt currently held in ID/EX
- i_if_id_rs  in  5  rs of instruction in IF/ID (instr[25:21])
- i_if_id_rt  in  5  rt of instruction in IF/ID (instr[20:16])
- i_branch_taken  in  1  branch/jump resolved taken in ID
- i_id_halt  in  1  Halt control line decoded in ID
- i_wb_halt  in  1  Halt control line reached MEM/WB output
- o_pc_en  out  1  PC write enable
- o_if_id_en  out  1  IF/ID enable
- o_if_id_flush  out  1  IF/ID loads zero (NOP)
- o_id_ex_en  out  1  ID/EX enable
- o_id_ex_flush  out  1  ID/EX loads zero (bubble)
- o_ex_mem_en  out  1  EX/MEM enable
- o_mem_wb_en  out  1  MEM/WB enable
- o_halted  out  1  program finished
- o_state  out  2  current FSM state code
- o_cycle_cnt  out  CNT_SZ  cycles in which pipeline advanced
- o_stall_cnt  out  CNT_SZ  load-use bubbles inserted

## Operation
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11. Reset value is IDLE.
- adv (advance cycle) = state is RUN or STEP.
- hazard = i_id_ex_mem_read & (i_id_ex_rt != 0) & (i_id_ex_rt == i_if_id_rs | i_id_ex_rt == i_if_id_rt).
- halt_pending: internal flag, reset 0. Set on adv & !hazard & i_id_halt. Cleared only by reset.
- Transitions:
  - IDLE: i_run goes to RUN; else i_step goes to STEP (i_run has priority).
  - RUN: i_wb_halt goes to HALTED; else !i_run goes to IDLE.
  - STEP: i_wb_halt goes to HALTED; else goes to IDLE (exactly one advance cycle).
  - HALTED: sticky until reset.
- Outputs when !adv: all enables and flushes 0.
- Outputs when adv, applied in priority order:
  - o_ex_mem_en = o_mem_wb_en = o_id_ex_en = 1.
  - If halt_pending: o_pc_en=0, o_if_id_en=0, o_if_id_flush=0, o_id_ex_flush=1. Fetch is frozen and the back end drains.
  - Else if hazard: o_pc_en=0, o_if_id_en=0, o_if_id_flush=0, o_id_ex_flush=1. This is a load-use bubble; a simultaneous i_branch_taken is ignored because the branch re-evaluates next cycle.
  - Else if i_id_halt: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=0. The halt enters ID/EX.
  - Else: o_pc_en=1, o_if_id_en=1, o_id_ex_flush=0, o_if_id_flush=i_branch_taken.
- Flush has priority over enable inside the pipeline register.
- o_halted = (state == HALTED).
- Counters:
  - o_cycle_cnt increments on every adv cycle.
  - o_stall_cnt increments on adv & hazard & !halt_pending.
  - Both wrap modulo 2^CNT_SZ, reset to 0, and hold in HALTED.

## Timing
- State, halt_pending and counters are registered. Enables and flushes are combinational from state, halt_pending and hazard inputs, valid in the same cycle.
- A single i_step produces exactly one cycle with adv=1. The cycle after the pulse is STEP, then IDLE.
- An i_step pulse while in RUN or STEP is ignored.
- i_wb_halt in an adv cycle: that cycle still advances, then HALTED follows. From that point all enables are 0 and o_halted=1.
- i_run deasserted in RUN: the current cycle still advances, and IDLE follows.
- Reset asserted mid-operation: immediately IDLE, all enables 0, counters 0, halt_pending 0, regardless of clock.
- Reset values: o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en, o_halted = 0; o_state=2'b00; counters=0.

## Test plan
- Reset then i_run=1, no hazards for 10 cycles: all enables 1, flushes 0, o_state=01, o_cycle_cnt=10.
- RUN with id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_stall_cnt=1. Same with rt=0 gives no stall.
- RUN with hazard and i_branch_taken both 1: o_if_id_flush=0 (stall wins). Next cycle without hazard: o_if_id_flush=1, o_pc_en=1.
- IDLE, pulse i_step three times at 4-cycle spacing: exactly 3 adv cycles, o_cycle_cnt=3, state returns to 00 after each step.
- RUN, i_id_halt=1 for one cycle, i_wb_halt=1 three cycles later: fetch frozen with o_id_ex_flush=1 until then, then o_state=11, o_halted=1, all enables 0, counters frozen.
- Assert i_reset low mid-RUN, between clock edges: outputs zero asynchronously, o_state=00, counters 0.
